// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory access controller.
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StRWait,
        StDone,
        StErr
    } dmemState_e;

    // Size code 3 is illegal; words need 4-byte and halves 2-byte alignment.
    function automatic logic isBadAccess(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_WORD: bad = (offset != 2'b00);
            SZ_HALF: bad = offset[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Byte-lane steering for stores and lane extract/extend for loads.
// Lane k occupies data bits [31-8k -: 8].
module dmem_lane_steer
    import dmem_pkg::*;
(
    input  logic [1:0]  wrSize,
    input  logic [1:0]  wrOffset,
    input  logic [31:0] wrData,
    output logic [3:0]  wrBe,
    output logic [31:0] wrLanes,
    input  logic [1:0]  rdSize,
    input  logic [1:0]  rdOffset,
    input  logic        rdSignExt,
    input  logic [31:0] rdData,
    output logic [31:0] rdAligned
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    always_comb begin
        wrBe    = 4'b1111;
        wrLanes = wrData;
        case (wrSize)
            SZ_HALF: begin
                if (wrOffset[1]) begin
                    wrBe    = 4'b1100;
                    wrLanes = {16'd0, wrData[15:0]};
                end else begin
                    wrBe    = 4'b0011;
                    wrLanes = {wrData[15:0], 16'd0};
                end
            end
            SZ_BYTE: begin
                wrBe    = 4'b0001 << wrOffset;
                // Lane k sits 8*(3-k) bits up, and 3-k equals ~k for a 2-bit k.
                wrLanes = {24'd0, wrData[7:0]} << {~wrOffset, 3'b000};
            end
            default: ;
        endcase
    end

    always_comb begin
        laneByte = 8'(rdData >> {~rdOffset, 3'b000});
        laneHalf = rdOffset[1] ? rdData[15:0] : rdData[31:16];
        case (rdSize)
            SZ_HALF: rdAligned = {{16{rdSignExt & laneHalf[15]}}, laneHalf};
            SZ_BYTE: rdAligned = {{24{rdSignExt & laneByte[7]}}, laneByte};
            default: rdAligned = rdData;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: round-robin CPU/DMA arbitration onto a single-port
// synchronous RAM with alignment checks, store lane steering and load extension.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_sign_ext,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [31:0]       cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_ack,
    output logic [31:0]       dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned ByteAddrW = ADDR_W + 2;

    dmemState_e stateQ, stateD;
    logic lastGrantQ, lastGrantD, ownerQ, ownerD;
    logic weQ, weD, signExtQ, signExtD;
    logic [1:0] sizeQ, sizeD;
    logic [ByteAddrW-1:0] addrQ, addrD;

    logic cpuAckQ, cpuAckD, cpuErrQ, cpuErrD, dmaAckQ, dmaAckD;
    logic memEnQ, memEnD, memWeQ, memWeD;
    logic [31:0] cpuRdataQ, cpuRdataD, dmaRdataQ, dmaRdataD, memWdataQ, memWdataD;
    logic [ADDR_W-1:0] memAddrQ, memAddrD;
    logic [3:0] memBeQ, memBeD;

    logic grantCpu, reqWe, reqSignExt, reqBad;
    logic [1:0] reqSize;
    logic [ByteAddrW-1:0] reqAddr;
    logic [31:0] reqWdata;
    logic [3:0] steerBe;
    logic [31:0] steerWdata, loadData;
    logic unusedAddrBits;

    // Address bits above the RAM range and the DMA byte offset are don't-care.
    assign unusedAddrBits = ^{cpu_addr[31:ByteAddrW], dma_addr[31:ByteAddrW], dma_addr[1:0]};

    // Candidate request; only consumed in StIdle.
    always_comb begin
        grantCpu   = cpu_req & (~dma_req | (lastGrantQ == REQ_DMA));
        reqWe      = grantCpu ? cpu_we : dma_we;
        reqAddr    = grantCpu ? cpu_addr[ByteAddrW-1:0] : {dma_addr[ByteAddrW-1:2], 2'b00};
        reqWdata   = grantCpu ? cpu_wdata : dma_wdata;
        reqSize    = grantCpu ? cpu_size : SZ_WORD;
        reqSignExt = grantCpu & cpu_sign_ext;
        reqBad     = grantCpu & isBadAccess(cpu_size, cpu_addr[1:0]);
    end

    dmem_lane_steer uLaneSteer (
        .wrSize   (reqSize),
        .wrOffset (reqAddr[1:0]),
        .wrData   (reqWdata),
        .wrBe     (steerBe),
        .wrLanes  (steerWdata),
        .rdSize   (sizeQ),
        .rdOffset (addrQ[1:0]),
        .rdSignExt(signExtQ),
        .rdData   (mem_rdata),
        .rdAligned(loadData)
    );

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        stateD     = stateQ;
        lastGrantD = lastGrantQ;
        ownerD     = ownerQ;
        weD        = weQ;
        sizeD      = sizeQ;
        signExtD   = signExtQ;
        addrD      = addrQ;
        cpuAckD    = 1'b0;
        cpuErrD    = 1'b0;
        dmaAckD    = 1'b0;
        cpuRdataD  = cpuRdataQ;
        dmaRdataD  = dmaRdataQ;
        memEnD     = 1'b0;
        memWeD     = 1'b0;
        memAddrD   = '0;
        memBeD     = '0;
        memWdataD  = '0;
        case (stateQ)
            StIdle: begin
                if (cpu_req || dma_req) begin
                    ownerD     = grantCpu ? REQ_CPU : REQ_DMA;
                    lastGrantD = grantCpu ? REQ_CPU : REQ_DMA;
                    weD        = reqWe;
                    sizeD      = reqSize;
                    signExtD   = reqSignExt;
                    addrD      = reqAddr;
                    if (reqBad) begin
                        stateD    = StErr;
                        cpuAckD   = 1'b1;
                        cpuErrD   = 1'b1;
                        cpuRdataD = '0;
                    end else begin
                        stateD    = StAccess;
                        memEnD    = 1'b1;
                        memWeD    = reqWe;
                        memAddrD  = reqAddr[ByteAddrW-1:2];
                        memBeD    = reqWe ? steerBe : 4'b1111;
                        memWdataD = reqWe ? steerWdata : '0;
                    end
                end
            end
            StAccess: begin
                if (weQ) begin
                    stateD  = StDone;
                    cpuAckD = (ownerQ == REQ_CPU);
                    dmaAckD = (ownerQ == REQ_DMA);
                end else begin
                    stateD = StRWait;
                end
            end
            StRWait: begin
                stateD = StDone;
                if (ownerQ == REQ_CPU) begin
                    cpuAckD   = 1'b1;
                    cpuRdataD = loadData;
                end else begin
                    dmaAckD   = 1'b1;
                    dmaRdataD = loadData;
                end
            end
            StDone:  stateD = StIdle;
            StErr:   stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ     <= StIdle;
            lastGrantQ <= REQ_DMA;
            ownerQ     <= REQ_CPU;
            weQ        <= 1'b0;
            sizeQ      <= SZ_WORD;
            signExtQ   <= 1'b0;
            addrQ      <= '0;
            cpuAckQ    <= 1'b0;
            cpuErrQ    <= 1'b0;
            dmaAckQ    <= 1'b0;
            cpuRdataQ  <= '0;
            dmaRdataQ  <= '0;
            memEnQ     <= 1'b0;
            memWeQ     <= 1'b0;
            memAddrQ   <= '0;
            memBeQ     <= '0;
            memWdataQ  <= '0;
        end else begin
            stateQ     <= stateD;
            lastGrantQ <= lastGrantD;
            ownerQ     <= ownerD;
            weQ        <= weD;
            sizeQ      <= sizeD;
            signExtQ   <= signExtD;
            addrQ      <= addrD;
            cpuAckQ    <= cpuAckD;
            cpuErrQ    <= cpuErrD;
            dmaAckQ    <= dmaAckD;
            cpuRdataQ  <= cpuRdataD;
            dmaRdataQ  <= dmaRdataD;
            memEnQ     <= memEnD;
            memWeQ     <= memWeD;
            memAddrQ   <= memAddrD;
            memBeQ     <= memBeD;
            memWdataQ  <= memWdataD;
        end
    end

    assign cpu_ack   = cpuAckQ;
    assign cpu_err   = cpuErrQ;
    assign cpu_rdata = cpuRdataQ;
    assign dma_ack   = dmaAckQ;
    assign dma_rdata = dmaRdataQ;
    assign mem_en    = memEnQ;
    assign mem_we    = memWeQ;
    assign mem_addr  = memAddrQ;
    assign mem_be    = memBeQ;
    assign mem_wdata = memWdataQ;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases plus randomized transactions
// checked against a byte-addressed big-endian memory model.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_sign_ext;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_ack, cpu_err;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:1023];
    logic [31:0] ramWord;
    logic [7:0]  modelMem [0:4095];
    logic [31:0] expCpuRdata, expDmaRdata;
    int checks = 0;
    int errors = 0;

    dmem_access_ctrl #(.ADDR_W(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_size    (cpu_size),
        .cpu_sign_ext(cpu_sign_ext),
        .cpu_ack     (cpu_ack),
        .cpu_err     (cpu_err),
        .cpu_rdata   (cpu_rdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_ack     (dma_ack),
        .dma_rdata   (dma_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM; read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ramWord = ram[mem_addr];
                for (int k = 0; k < 4; k++)
                    if (mem_be[k]) ramWord[31-8*k -: 8] = mem_wdata[31-8*k -: 8];
                ram[mem_addr] <= ramWord;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sizeBytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    endfunction

    // Bytes of d (most significant first) occupy lanes off .. off+n-1.
    task automatic expSteer(input logic [1:0] sz, input logic [1:0] off, input logic [31:0] d,
                            output logic [3:0] be, output logic [31:0] lanes);
        int n;
        int o;
        n = sizeBytes(sz);
        o = int'(off);
        be = '0;
        lanes = '0;
        for (int k = 0; k < 4; k++) begin
            if (k >= o && k < o + n) begin
                be[k] = 1'b1;
                lanes[31-8*k -: 8] = 8'(d >> (8 * (n - 1 - (k - o))));
            end
        end
    endtask

    task automatic modelStore(input logic [11:0] a, input logic [1:0] sz, input logic [31:0] d);
        int n;
        n = sizeBytes(sz);
        for (int j = 0; j < n; j++) modelMem[int'(a) + j] = 8'(d >> (8 * (n - 1 - j)));
    endtask

    function automatic logic [31:0] modelLoad(input logic [11:0] a, input logic [1:0] sz,
                                              input bit sx);
        int n;
        logic [31:0] v;
        n = sizeBytes(sz);
        v = '0;
        for (int j = 0; j < n; j++) v = (v << 8) | 32'(modelMem[int'(a) + j]);
        if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic idleInputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_size = '0; cpu_sign_ext = 0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic checkOutputsZero();
        checkVal("zeroCtl", 32'({cpu_ack, cpu_err, dma_ack, mem_en, mem_we, mem_be}), 32'd0);
        checkVal("zeroMemAddr", 32'(mem_addr), 32'd0);
        checkVal("zeroMemWdata", mem_wdata, 32'd0);
        checkVal("zeroCpuRdata", cpu_rdata, 32'd0);
        checkVal("zeroDmaRdata", dma_rdata, 32'd0);
    endtask

    // One request from an idle controller; checks RAM strobes, latency, ack data.
    task automatic runTxn(input bit isCpu, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input bit sx);
        logic [1:0] sz, off;
        logic [11:0] base;
        bit expErr;
        int expLat, lat, memEnCnt, memEnAt, otherAcks;
        logic [3:0] expBe;
        logic [31:0] expLanes, ackCpuRd, ackDmaRd;
        logic ackErr;
        sz     = isCpu ? size : 2'd0;
        off    = isCpu ? addr[1:0] : 2'd0;
        base   = isCpu ? addr[11:0] : {addr[11:2], 2'b00};
        expErr = isCpu && (size == 2'd3 || (size == 2'd0 && off != 2'd0) ||
                           (size == 2'd1 && off[0]));
        expLat = expErr ? 1 : (we ? 2 : 3);
        expSteer(sz, off, wdata, expBe, expLanes);
        if (isCpu) begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
            cpu_size = size; cpu_sign_ext = sx;
        end else begin
            dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end
        lat = 0; memEnCnt = 0; memEnAt = 0; otherAcks = 0;
        ackErr = 0; ackCpuRd = '0; ackDmaRd = '0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (mem_en) begin
                memEnCnt++;
                memEnAt = c;
                checkVal("memWe", 32'(mem_we), 32'(we));
                checkVal("memAddr", 32'(mem_addr), 32'(base[11:2]));
                checkVal("memBe", 32'(mem_be), we ? 32'(expBe) : 32'hF);
                if (we) checkVal("memWdata", mem_wdata, expLanes);
            end
            if (isCpu ? dma_ack : cpu_ack) otherAcks++;
            if (isCpu ? cpu_ack : dma_ack) begin
                lat = c;
                ackErr = cpu_err;
                ackCpuRd = cpu_rdata;
                ackDmaRd = dma_rdata;
            end
        end
        idleInputs();
        checkVal("ackLatency", lat, expLat);
        checkVal("memEnCount", memEnCnt, expErr ? 0 : 1);
        checkVal("memEnCycle", memEnAt, expErr ? 0 : 1);
        checkVal("otherAck", otherAcks, 0);
        if (isCpu) checkVal("cpuErr", 32'(ackErr), 32'(expErr));
        if (expErr) expCpuRdata = '0;
        else if (we) modelStore(base, sz, wdata);
        else if (isCpu) expCpuRdata = modelLoad(base, sz, sx);
        else expDmaRdata = modelLoad(base, sz, 1'b0);
        checkVal("cpuRdata", ackCpuRd, expCpuRdata);
        checkVal("dmaRdata", ackDmaRd, expDmaRdata);
        @(posedge clk); #1;
        checkVal("ackPulse", 32'({cpu_ack, dma_ack}), 32'd0);
    endtask

    // Both requesters held through four acks: expect CPU, DMA, CPU, DMA.
    task automatic tieTest();
        int acks, accesses;
        logic [3:0] order;
        logic [31:0] dmaWdata;
        logic [9:0] dmaAddr;
        logic [3:0] dmaBe;
        acks = 0; accesses = 0; order = '0;
        dmaWdata = '0; dmaAddr = '0; dmaBe = '0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1122_3344; cpu_size = 2'd0;
        dma_req = 1; dma_we = 1; dma_addr = 32'h10; dma_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 40 && acks < 4; c++) begin
            @(posedge clk); #1;
            if (mem_en) begin
                if (accesses == 1) begin
                    dmaWdata = mem_wdata; dmaAddr = mem_addr; dmaBe = mem_be;
                end
                accesses++;
            end
            if (cpu_ack || dma_ack) begin
                order = {order[2:0], dma_ack};
                acks++;
            end
        end
        idleInputs();
        checkVal("tieAcks", acks, 4);
        checkVal("tieOrder", 32'(order), 32'b0101);
        checkVal("tieDmaAddr", 32'(dmaAddr), 32'd4);
        checkVal("tieDmaBe", 32'(dmaBe), 32'hF);
        checkVal("tieDmaWdata", dmaWdata, 32'hDEAD_BEEF);
        modelStore(12'h20, 2'd0, 32'h1122_3344);
        modelStore(12'h10, 2'd0, 32'hDEAD_BEEF);
        @(posedge clk); #1;
    endtask

    initial begin
        idleInputs();
        expCpuRdata = '0;
        expDmaRdata = '0;
        for (int i = 0; i < 4096; i++) modelMem[i] = '0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checkOutputsZero();
        rst = 0;
        tieTest();

        runTxn(1, 1, 32'h0000_0006, 32'h0000_00A5, 2'd2, 0);
        runTxn(0, 1, 32'h0000_0008, 32'h8001_1234, 2'd0, 0);
        runTxn(1, 0, 32'h0000_0008, 32'h0, 2'd1, 1);
        checkVal("planHalfSx", cpu_rdata, 32'hFFFF_8001);
        runTxn(1, 0, 32'h0000_0008, 32'h0, 2'd1, 0);
        checkVal("planHalfZx", cpu_rdata, 32'h0000_8001);
        runTxn(1, 1, 32'h0000_0003, 32'h1234_5678, 2'd1, 0);
        runTxn(1, 1, 32'h0000_0000, 32'h1234_5678, 2'd3, 0);
        checkVal("planErrRdata", cpu_rdata, 32'h0);

        // CPU drops req right after grant; DMA arrives during DONE and waits for IDLE.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h2D; cpu_wdata = 32'h5A; cpu_size = 2'd2;
        @(posedge clk); #1;
        checkVal("dropMemEn", 32'(mem_en), 32'd1);
        cpu_req = 0;
        @(posedge clk); #1;
        checkVal("dropAck", 32'(cpu_ack), 32'd1);
        dma_req = 1; dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        checkVal("dropIdleQuiet", 32'({cpu_ack, dma_ack, mem_en}), 32'd0);
        @(posedge clk); #1;
        checkVal("dropNextGrant", 32'(mem_en), 32'd1);
        @(posedge clk); #1;
        checkVal("dropDmaAck", 32'(dma_ack), 32'd1);
        idleInputs();
        modelStore(12'h2D, 2'd2, 32'h5A);
        modelStore(12'h30, 2'd0, 32'hCAFE_F00D);
        @(posedge clk); #1;

        for (int w = 0; w < 16; w++) runTxn(0, 1, 32'(w * 4), $urandom(), 2'd0, 0);
        for (int i = 0; i < 150; i++) begin
            runTxn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_F03F,
                   $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset while a load is in RWAIT: no ack, everything cleared.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; cpu_size = 2'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        cpu_req = 0;
        @(posedge clk); #1;
        checkOutputsZero();
        rst = 0;
        expCpuRdata = '0;
        expDmaRdata = '0;
        @(posedge clk); #1;
        checkVal("rstNoAck", 32'({cpu_ack, dma_ack, mem_en}), 32'd0);
        tieTest();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
